// File: rtl/uart_tx_sched.sv
// UART transmit sequencer: frames bytes on txd from 16x en_tx ticks
// and owns the TX baud divisor, applying staged config between frames.
module uart_tx_sched #(
   parameter int          DIV_W       = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd3,
   parameter int          OSR         = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_tx,
   output logic [15:0] div_tx,
   input  logic        cfg_we,
   input  logic [15:0] cfg_div,
   input  logic        cfg_parity_en,
   input  logic        cfg_parity_odd,
   input  logic        cfg_two_stop,
   output logic        cfg_err,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        txd,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2
   } state_t;

   localparam logic [3:0] TICK_MAX = 4'(OSR - 1);

   state_t      state_q, state_d;
   logic [3:0]  tick_q, tick_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        txd_q, txd_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        pend_q, pend_d;
   logic [15:0] sh_div_q, sh_div_d;
   logic        sh_pen_q, sh_pen_d;
   logic        sh_odd_q, sh_odd_d;
   logic        sh_two_q, sh_two_d;
   logic [15:0] div_q, div_d;
   logic        pen_q, pen_d;
   logic        odd_q, odd_d;
   logic        two_q, two_d;
   logic        bit_end;

   assign tx_ready = (state_q == IDLE) && !pend_q;
   assign bit_end  = en_tx && (tick_q == TICK_MAX);
   assign div_tx   = div_q;
   assign cfg_err  = err_q;
   assign txd      = txd_q;
   assign busy     = busy_q;

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      err_d    = 1'b0;
      pend_d   = pend_q;
      sh_div_d = sh_div_q;
      sh_pen_d = sh_pen_q;
      sh_odd_d = sh_odd_q;
      sh_two_d = sh_two_q;
      div_d    = div_q;
      pen_d    = pen_q;
      odd_d    = odd_q;
      two_d    = two_q;

      if (state_q == IDLE && pend_q) begin
         div_d  = sh_div_q;
         pen_d  = sh_pen_q;
         odd_d  = sh_odd_q;
         two_d  = sh_two_q;
         pend_d = 1'b0;
      end

      // zero or over-wide divisors would stall or truncate the ticks
      if (cfg_we) begin
         if (cfg_div == '0 || |cfg_div[15:DIV_W]) begin
            err_d = 1'b1;
         end else begin
            sh_div_d = cfg_div;
            sh_pen_d = cfg_parity_en;
            sh_odd_d = cfg_parity_odd;
            sh_two_d = cfg_two_stop;
            pend_d   = 1'b1;
         end
      end

      if (state_q == IDLE) begin
         if (tx_valid && tx_ready) begin
            shift_d = tx_data;
            par_d   = (^tx_data) ^ odd_q;
            tick_d  = '0;
            bit_d   = '0;
            state_d = START;
         end
      end else if (en_tx) begin
         tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
      end

      if (bit_end) begin
         unique case (state_q)
            START:   state_d = DATA;
            DATA: begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7)
                  state_d = pen_q ? PARITY : STOP1;
               else
                  bit_d = bit_q + 3'd1;
            end
            PARITY:  state_d = STOP1;
            STOP1:   state_d = two_q ? STOP2 : IDLE;
            STOP2:   state_d = IDLE;
            default: state_d = state_q;
         endcase
      end

      unique case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = par_d;
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         txd_q    <= 1'b1;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
         sh_div_q <= DEFAULT_DIV;
         sh_pen_q <= 1'b0;
         sh_odd_q <= 1'b0;
         sh_two_q <= 1'b0;
         div_q    <= DEFAULT_DIV;
         pen_q    <= 1'b0;
         odd_q    <= 1'b0;
         two_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         txd_q    <= txd_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
         sh_div_q <= sh_div_d;
         sh_pen_q <= sh_pen_d;
         sh_odd_q <= sh_odd_d;
         sh_two_q <= sh_two_d;
         div_q    <= div_d;
         pen_q    <= pen_d;
         odd_q    <= odd_d;
         two_q    <= two_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural baud divisor
// driving en_tx from the DUT's own div_tx.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en_tx = 1'b0;
   logic [15:0] div_tx;
   logic        cfg_we = 1'b0;
   logic [15:0] cfg_div = '0;
   logic        cfg_parity_en = 1'b0;
   logic        cfg_parity_odd = 1'b0;
   logic        cfg_two_stop = 1'b0;
   logic        cfg_err;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        txd;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;
   int n_acc = 0;
   int dcnt = 0;

   uart_tx_sched dut (
      .clk(clk),
      .rst(rst),
      .en_tx(en_tx),
      .div_tx(div_tx),
      .cfg_we(cfg_we),
      .cfg_div(cfg_div),
      .cfg_parity_en(cfg_parity_en),
      .cfg_parity_odd(cfg_parity_odd),
      .cfg_two_stop(cfg_two_stop),
      .cfg_err(cfg_err),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .txd(txd),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // divisor model: one-cycle tick every div_tx+1 clocks
   always @(negedge clk) begin
      if (!rst) begin
         dcnt = 0;
         en_tx = 1'b0;
      end else if (dcnt >= int'(div_tx)) begin
         dcnt = 0;
         en_tx = 1'b1;
      end else begin
         dcnt = dcnt + 1;
         en_tx = 1'b0;
      end
   end

   always @(posedge clk)
      if (rst && tx_valid && tx_ready) n_acc = n_acc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] fbits(input logic [7:0] b,
                                         input bit pen, input bit odd);
      logic [11:0] r;
      r = 12'hFFF;
      r[0] = 1'b0;
      r[8:1] = b;
      if (pen) r[9] = (^b) ^ odd;
      return r;
   endfunction

   task automatic cfg_write(input logic [15:0] d, input bit pen,
                            input bit odd, input bit two);
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_div = d;
      cfg_parity_en = pen;
      cfg_parity_odd = odd;
      cfg_two_stop = two;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // returns just after the accepting posedge
   task automatic send(input logic [7:0] b, input bit hold);
      int n;
      @(negedge clk);
      tx_data = b;
      tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [7:0] b,
                              input bit pen, input bit odd,
                              input bit two, input int L,
                              input bit exp_rdy, input int wr_at);
      logic [11:0] exp;
      int nb, t, k, t1, tend;
      exp = fbits(b, pen, odd);
      nb = 10 + int'(pen) + int'(two);
      t = 0;
      k = 0;
      t1 = -1;
      tend = -1;
      while (tend < 0 && t < nb * L + 300) begin
         @(negedge clk);
         if (t == wr_at) begin
            cfg_we = 1'b1;
            cfg_div = 16'd7;
            cfg_parity_en = 1'b0;
            cfg_parity_odd = 1'b0;
            cfg_two_stop = 1'b0;
         end else begin
            cfg_we = 1'b0;
         end
         if (t1 < 0 && txd) t1 = t;
         if (k < nb && t == k * L + L / 2) begin
            chk($sformatf("%s_bit%0d", tag, k), 32'(txd), 32'(exp[k]));
            k++;
         end
         if (!busy) tend = t;
         t++;
      end
      chk({tag, "_end"}, 32'(tend >= 0), 32'd1);
      chk({tag, "_nbits"}, 32'(k), 32'(nb));
      if (exp[1])
         chk({tag, "_len"}, 32'(tend - t1), 32'((nb - 1) * L));
      chk({tag, "_rdy"}, 32'(tx_ready), 32'(exp_rdy));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy", 32'(tx_ready), 32'd1);
      chk("rst_div", 32'(div_tx), 32'd3);
      chk("rst_err", 32'(cfg_err), 32'd0);
      rst = 1'b1;

      send(8'hA5, 1'b0);
      check_frame("basic", 8'hA5, 0, 0, 0, 64, 1, -1);

      cfg_write(16'd3, 1, 0, 0);
      chk("pend_rdy", 32'(tx_ready), 32'd0);
      @(negedge clk);
      chk("apply_rdy", 32'(tx_ready), 32'd1);
      send(8'hA5, 1'b0);
      check_frame("par_even", 8'hA5, 1, 0, 0, 64, 1, -1);

      cfg_write(16'd3, 1, 1, 1);
      @(negedge clk);
      send(8'hA5, 1'b0);
      check_frame("par_odd2", 8'hA5, 1, 1, 1, 64, 1, -1);

      cfg_write(16'd3, 0, 0, 0);
      @(negedge clk);
      send(8'hA5, 1'b0);
      check_frame("defer", 8'hA5, 0, 0, 0, 64, 0, 200);
      chk("defer_div_old", 32'(div_tx), 32'd3);
      @(negedge clk);
      chk("defer_div_new", 32'(div_tx), 32'd7);
      chk("defer_rdy", 32'(tx_ready), 32'd1);
      send(8'h3C, 1'b0);
      check_frame("div7", 8'h3C, 0, 0, 0, 128, 1, -1);

      cfg_write(16'd0, 0, 0, 0);
      chk("rej0_err", 32'(cfg_err), 32'd1);
      chk("rej0_rdy", 32'(tx_ready), 32'd1);
      @(negedge clk);
      chk("rej0_err_off", 32'(cfg_err), 32'd0);
      cfg_write(16'h0100, 0, 0, 0);
      chk("rejw_err", 32'(cfg_err), 32'd1);
      chk("rejw_rdy", 32'(tx_ready), 32'd1);
      @(negedge clk);
      chk("rejw_err_off", 32'(cfg_err), 32'd0);
      chk("rej_div", 32'(div_tx), 32'd7);
      chk("rej_rdy", 32'(tx_ready), 32'd1);

      cfg_write(16'd5, 0, 0, 0);
      @(negedge clk);
      chk("div5", 32'(div_tx), 32'd5);
      n_acc = 0;
      send(8'h00, 1'b1);
      tx_data = 8'hFF;
      check_frame("b2b_0", 8'h00, 0, 0, 0, 96, 1, -1);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      chk("b2b_gap_busy", 32'(busy), 32'd1);
      chk("b2b_gap_txd", 32'(txd), 32'd0);
      check_frame("b2b_1", 8'hFF, 0, 0, 0, 96, 1, -1);
      repeat (5) @(negedge clk);
      chk("b2b_acc", 32'(n_acc), 32'd2);

      send(8'hA5, 1'b0);
      repeat (100) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_txd", 32'(txd), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rdy", 32'(tx_ready), 32'd1);
      chk("arst_div", 32'(div_tx), 32'd3);
      @(negedge clk);
      rst = 1'b1;
      begin
         int nb;
         nb = 0;
         repeat (200) begin
            @(negedge clk);
            if (busy || !txd) nb++;
         end
         chk("arst_quiet", 32'(nb), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
